tlcd_bus_scheduler: RTL and testbench

- Owns the shared text-LCD bus (TLCD_E/RS/RW/DATA).
- After reset, runs the HD44780 power-up command sequence.
- Then arbitrates single-byte write transactions from two requesters (port 0 = CGRAM font loader, port 1 = text/DDRAM writer) with round-robin priority.
- Generates E-pulse setup/high/hold timing and per-command execution waits, so requesters never touch the pins.

---
 rtl/tlcd_pkg.sv | 36 +++
 rtl/tlcd_rr_arbiter2.sv | 22 ++
 rtl/tlcd_bus_scheduler.sv | 136 +++++++++++++
 tb/tb_tlcd_bus_scheduler.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/tlcd_pkg.sv
// tlcd_pkg: shared FSM states, HD44780 command bytes and the power-up init ROM
// for the text-LCD bus scheduler.
package tlcd_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT_ISSUE,
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    EXEC,
    ACK
  } state_e;

  localparam logic [7:0] FUNC_SET_8B2L = 8'h38;
  localparam logic [7:0] DISP_ON       = 8'h0C;
  localparam logic [7:0] ENTRY_INC     = 8'h06;
  localparam logic [7:0] CLEAR         = 8'h01;
  localparam logic [7:0] CGRAM_BASE    = 8'h40;
  localparam logic [7:0] DDRAM_BASE    = 8'h80;

  localparam logic [1:0] INIT_LAST = 2'd3;

  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    return idx == 2'd0 ? FUNC_SET_8B2L :
           idx == 2'd1 ? DISP_ON :
           idx == 2'd2 ? ENTRY_INC : CLEAR;
  endfunction

  // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
    return !rs && d[7:2] == 6'd0 && d != 8'd0;
  endfunction

endpackage

// File: rtl/tlcd_rr_arbiter2.sv
// tlcd_rr_arbiter2: two-way round-robin grant; on a tie the port not granted
// last wins. The pointer resets to 1 so port 0 wins the first tie.
module tlcd_rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  logic last_q;

  always_comb begin
    gnt_o[0] = req_i[0] & (~req_i[1] | last_q);
    gnt_o[1] = req_i[1] & (~req_i[0] | ~last_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) last_q <= 1'b1;
    else if (en_i && |req_i) last_q <= gnt_o[1];

endmodule

// File: rtl/tlcd_bus_scheduler.sv
// tlcd_bus_scheduler: owns the HD44780 bus, runs the power-up init sequence,
// then serves single-byte writes from two requesters with E-pulse timing.
module tlcd_bus_scheduler
  import tlcd_pkg::*;
#(
  parameter logic [15:0] POWERUP_CYC = 16'd40000,
  parameter logic [3:0]  SETUP_CYC   = 4'd2,
  parameter logic [3:0]  E_HIGH_CYC  = 4'd4,
  parameter logic [3:0]  HOLD_CYC    = 4'd1,
  parameter logic [15:0] EXEC_CYC    = 16'd50,
  parameter logic [15:0] CLEAR_CYC   = 16'd2000
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       REQ0,
  input  logic       RS0,
  input  logic [7:0] DATA0,
  output logic       ACK0,
  input  logic       REQ1,
  input  logic       RS1,
  input  logic [7:0] DATA1,
  output logic       ACK1,
  output logic       INIT_DONE,
  output logic       TLCD_E,
  output logic       TLCD_RS,
  output logic       TLCD_RW,
  output logic [7:0] TLCD_DATA
);

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [15:0] lim;
  logic        cnt_done;
  logic [1:0]  idx_q;
  logic [1:0]  gnt;
  logic [1:0]  elig;
  logic        e_q;
  logic        rs_q;
  logic [7:0]  data_q;
  logic        port_q;
  logic        ack0_q;
  logic        ack1_q;
  logic        init_done_q;

  param_ok: assert property (@(posedge CLK)
    POWERUP_CYC != 16'd0 && SETUP_CYC != 4'd0 && E_HIGH_CYC != 4'd0 &&
    HOLD_CYC != 4'd0 && EXEC_CYC != 16'd0 && CLEAR_CYC != 16'd0);

  always_comb begin
    lim = state_q == PWR_WAIT ? POWERUP_CYC :
          state_q == SETUP    ? {12'd0, SETUP_CYC} :
          state_q == PULSE    ? {12'd0, E_HIGH_CYC} :
          state_q == HOLD     ? {12'd0, HOLD_CYC} :
          is_long_cmd(rs_q, data_q) ? CLEAR_CYC : EXEC_CYC;
    cnt_done = cnt_q == lim - 16'd1;
    elig = {REQ1 & ~ack1_q, REQ0 & ~ack0_q} & {2{init_done_q}};
  end

  tlcd_rr_arbiter2 u_arb (
    .clk_i (CLK),
    .rst_ni(RESETN),
    .req_i (elig),
    .en_i  (state_q == IDLE),
    .gnt_o (gnt)
  );

  // Counter restarts on every phase change and is idle outside timed states,
  // so it never exceeds lim-1 and cannot wrap.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q     <= PWR_WAIT;
      cnt_q       <= '0;
      idx_q       <= '0;
      e_q         <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= '0;
      port_q      <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      cnt_q <= (cnt_done || state_q inside {IDLE, INIT_ISSUE, ACK}) ? '0 : cnt_q + 16'd1;
      case (state_q)
        PWR_WAIT: if (cnt_done) state_q <= INIT_ISSUE;
        INIT_ISSUE: begin
          data_q  <= init_rom(idx_q);
          rs_q    <= 1'b0;
          state_q <= SETUP;
        end
        IDLE: if (|gnt) begin
          data_q  <= gnt[0] ? DATA0 : DATA1;
          rs_q    <= gnt[0] ? RS0 : RS1;
          port_q  <= gnt[1];
          state_q <= SETUP;
        end
        SETUP: if (cnt_done) begin
          e_q     <= 1'b1;
          state_q <= PULSE;
        end
        PULSE: if (cnt_done) begin
          e_q     <= 1'b0;
          state_q <= HOLD;
        end
        HOLD: if (cnt_done) state_q <= EXEC;
        EXEC: if (cnt_done) begin
          if (init_done_q) begin
            ack0_q  <= ~port_q;
            ack1_q  <= port_q;
            state_q <= ACK;
          end else if (idx_q == INIT_LAST) begin
            init_done_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            idx_q   <= idx_q + 2'd1;
            state_q <= INIT_ISSUE;
          end
        end
        ACK: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= PWR_WAIT;
      endcase
    end
  end

  assign ACK0      = ack0_q;
  assign ACK1      = ack1_q;
  assign INIT_DONE = init_done_q;
  assign TLCD_E    = e_q;
  assign TLCD_RS   = rs_q;
  assign TLCD_RW   = 1'b0;
  assign TLCD_DATA = data_q;

endmodule

// File: tb/tb_tlcd_bus_scheduler.sv
// tb_tlcd_bus_scheduler: scoreboard bench; stimulus queues expected bus writes,
// a monitor pops them on each E pulse and checks completion timing.
module tb_tlcd_bus_scheduler;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic       REQ0 = 1'b0, RS0 = 1'b0, REQ1 = 1'b0, RS1 = 1'b0;
  logic [7:0] DATA0 = 8'h00, DATA1 = 8'h00;
  logic       ACK0, ACK1, INIT_DONE, TLCD_E, TLCD_RS, TLCD_RW;
  logic [7:0] TLCD_DATA;

  tlcd_bus_scheduler #(.POWERUP_CYC(16'd20)) dut (
    .CLK(CLK), .RESETN(RESETN),
    .REQ0(REQ0), .RS0(RS0), .DATA0(DATA0), .ACK0(ACK0),
    .REQ1(REQ1), .RS1(RS1), .DATA1(DATA1), .ACK1(ACK1),
    .INIT_DONE(INIT_DONE), .TLCD_E(TLCD_E), .TLCD_RS(TLCD_RS),
    .TLCD_RW(TLCD_RW), .TLCD_DATA(TLCD_DATA)
  );

  always #5 CLK = ~CLK;

  // port 2 marks an init command: completes by INIT_DONE or next pulse, never by ACK
  typedef struct packed {
    logic [1:0]  port;
    logic        rs;
    logic [7:0]  data;
    logic [15:0] wt;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, got, req, $time);
    end
  endtask

  task automatic push(input logic [1:0] p, input logic rs, input logic [7:0] d, input logic [15:0] wt);
    exp_q.push_back({p, rs, d, wt});
  endtask

  task automatic push_init();
    push(2'd2, 1'b0, 8'h38, 16'd50);
    push(2'd2, 1'b0, 8'h0C, 16'd50);
    push(2'd2, 1'b0, 8'h06, 16'd50);
    push(2'd2, 1'b0, 8'h01, 16'd2000);
  endtask

  // Single request; checks the bus one cycle after grant and grant-to-ACK latency (wt+8).
  task automatic do_req(input logic p, input logic rs, input logic [7:0] d, input logic [7:0] d2,
                        input logic [15:0] wt);
    int n;
    logic hit;
    push({1'b0, p}, rs, d, wt);
    @(negedge CLK);
    if (p) begin REQ1 = 1'b1; RS1 = rs; DATA1 = d; end
    else begin REQ0 = 1'b1; RS0 = rs; DATA0 = d; end
    n = 0;
    hit = 1'b0;
    while (!hit && n < 5000) begin
      @(negedge CLK);
      n++;
      if (n == 1) begin
        chk("bus_after_grant", {22'd0, TLCD_E, TLCD_RS, TLCD_DATA}, {22'd0, 1'b0, rs, d});
        if (p) DATA1 = d2; else DATA0 = d2;
      end
      hit = p ? ACK1 : ACK0;
    end
    chk("grant_to_ack", n, 32'(wt) + 32'd8);
    if (p) REQ1 = 1'b0; else REQ0 = 1'b0;
  endtask

  initial begin : monitor
    exp_t cur;
    logic have, pe, pd;
    logic [2:0] got;
    int rise, ncyc;
    have = 1'b0; pe = 1'b0; pd = 1'b0; rise = 0; ncyc = 0; cur = '0;
    forever begin
      @(negedge CLK);
      ncyc++;
      if (!RESETN) begin
        have = 1'b0; pe = 1'b0; pd = 1'b0;
      end else begin
        if (TLCD_E && !pe) begin
          if (have && cur.port == 2'd2) chk("init_gap", ncyc - rise, 32'(cur.wt) + 32'd8);
          else chk("ack_missing_before_next_pulse", {31'd0, have}, 32'd0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got rs=%0d data=0x%02h, required no pulse", TLCD_RS, TLCD_DATA);
            have = 1'b0;
          end else begin
            cur = exp_q.pop_front();
            have = 1'b1;
            rise = ncyc;
            chk("bus_at_e_rise", {23'd0, TLCD_RS, TLCD_DATA}, {23'd0, cur.rs, cur.data});
          end
        end
        if (!TLCD_E && pe && have) begin
          chk("e_high_cycles", ncyc - rise, 32'd4);
          chk("bus_at_e_fall", {23'd0, TLCD_RS, TLCD_DATA}, {23'd0, cur.rs, cur.data});
        end
        if (ACK0 || ACK1 || (INIT_DONE && !pd)) begin
          got = (ACK0 && ACK1) ? 3'd3 : ACK0 ? 3'd0 : ACK1 ? 3'd1 : 3'd2;
          chk("completion_port", {29'd0, got}, have ? {30'd0, cur.port} : 32'd4);
          if (have) chk("completion_latency", ncyc - rise, 32'(cur.wt) + 32'd5);
          have = 1'b0;
        end
        pe = TLCD_E;
        pd = INIT_DONE;
      end
    end
  end

  initial begin : stim
    int n, acks;
    #12;
    chk("reset_outputs", {21'd0, TLCD_E, TLCD_RS, TLCD_RW, TLCD_DATA, ACK0, ACK1, INIT_DONE}, 32'd0);
    push_init();
    @(negedge CLK);
    RESETN = 1'b1;
    n = 0;
    while (!TLCD_E && n < 100) begin @(negedge CLK); n++; end
    chk("release_to_first_e", n, 32'd23);
    n = 0;
    while (!INIT_DONE && n < 5000) begin @(negedge CLK); n++; end
    chk("init_done", {31'd0, INIT_DONE}, 32'd1);

    do_req(1'b0, 1'b1, 8'h1F, 8'h1F, 16'd50);
    do_req(1'b1, 1'b0, 8'h01, 8'h01, 16'd2000);
    do_req(1'b1, 1'b0, 8'h80, 8'h80, 16'd50);

    push(2'd0, 1'b1, 8'h41, 16'd50);
    push(2'd1, 1'b1, 8'h42, 16'd50);
    push(2'd0, 1'b1, 8'h41, 16'd50);
    push(2'd1, 1'b1, 8'h42, 16'd50);
    @(negedge CLK);
    REQ0 = 1'b1; RS0 = 1'b1; DATA0 = 8'h41;
    REQ1 = 1'b1; RS1 = 1'b1; DATA1 = 8'h42;
    acks = 0;
    n = 0;
    while (acks < 4 && n < 1000) begin
      @(negedge CLK);
      n++;
      if (ACK0 || ACK1) acks++;
    end
    chk("rr_ack_count", acks, 32'd4);
    REQ0 = 1'b0; REQ1 = 1'b0;

    do_req(1'b0, 1'b0, 8'h40, 8'h55, 16'd50);

    push(2'd0, 1'b1, 8'h48, 16'd50);
    @(negedge CLK);
    REQ0 = 1'b1; RS0 = 1'b1; DATA0 = 8'h48;
    n = 0;
    while (!TLCD_E && n < 200) begin @(negedge CLK); n++; end
    chk("e_high_before_reset", {31'd0, TLCD_E}, 32'd1);
    #1 RESETN = 1'b0;
    REQ0 = 1'b0;
    #1 chk("async_reset_outputs",
           {21'd0, TLCD_E, TLCD_RS, TLCD_RW, TLCD_DATA, ACK0, ACK1, INIT_DONE}, 32'd0);
    exp_q.delete();
    push_init();
    repeat (3) @(negedge CLK);
    RESETN = 1'b1;
    n = 0;
    while (!INIT_DONE && n < 5000) begin @(negedge CLK); n++; end
    chk("init_done_after_reset", {31'd0, INIT_DONE}, 32'd1);
    do_req(1'b1, 1'b1, 8'h21, 8'h21, 16'd50);

    repeat (5) @(negedge CLK);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
